// File: rtl/result_bcd_converter_if.sv
// Result/flag capture and BCD output bundle between
// the ALU side and the display-side converter.
`timescale 1ns/1ps
interface result_bcd_converter_if #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
);
   logic                  start;
   logic                  signed_mode;
   logic [WIDTH-1:0]      result;
   logic                  z_in;
   logic                  n_in;
   logic                  c_in;
   logic                  o_in;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
   logic                  neg;
   logic [2:0]            ndig;
   logic [3:0]            flags_q;

   modport master (
      output start, signed_mode, result,
      output z_in, n_in, c_in, o_in,
      input  busy, done, bcd, neg, ndig, flags_q
   );

   modport slave (
      input  start, signed_mode, result,
      input  z_in, n_in, c_in, o_in,
      output busy, done, bcd, neg, ndig, flags_q
   );
endinterface

// File: rtl/result_bcd_converter.sv
// Iterative double-dabble converter: ALU result to
// packed BCD with sign, digit count and captured flags.
`timescale 1ns/1ps
module result_bcd_converter #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic clk,
   input  logic rst_n,
   result_bcd_converter_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam int BW = 4 * DIGITS;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic [BW-1:0]   scr_q, scr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            negp_q, negp_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [BW-1:0]   bcd_q, bcd_d;
   logic            neg_q, neg_d;
   logic [2:0]      ndig_q, ndig_d;
   logic [3:0]      flags_q, flags_d;

   logic [BW-1:0]    adj;
   logic [BW-1:0]    scr_sh;
   logic [WIDTH-1:0] bin_sh;
   logic [WIDTH-1:0] mag;
   logic [2:0]       nd;

   always_comb begin
      adj = scr_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (adj[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
      scr_sh = {adj[BW-2:0], bin_q[WIDTH-1]};
      bin_sh = {bin_q[WIDTH-2:0], 1'b0};
      nd = 3'd1;
      for (int i = 1; i < DIGITS; i++) begin
         if (scr_sh[4*i +: 4] != 4'd0)
            nd = 3'(i + 1);
      end
   end

   // 0x8000 negates to itself, which is the right unsigned magnitude
   always_comb begin
      mag = bus.result;
      if (bus.signed_mode && bus.result[WIDTH-1])
         mag = ~bus.result + WIDTH'(1);
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      scr_d   = scr_q;
      cnt_d   = cnt_q;
      negp_d  = negp_q;
      busy_d  = busy_q;
      done_d  = done_q;
      bcd_d   = bcd_q;
      neg_d   = neg_q;
      ndig_d  = ndig_q;
      flags_d = flags_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               flags_d = {bus.z_in, bus.n_in,
                          bus.c_in, bus.o_in};
               negp_d  = bus.signed_mode &
                         bus.result[WIDTH-1];
               bin_d   = mag;
               scr_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            scr_d = scr_sh;
            bin_d = bin_sh;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               bcd_d   = scr_sh;
               neg_d   = negp_q;
               ndig_d  = nd;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = DONE;
            end
         end
         DONE: begin
            done_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            done_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         bin_q   <= '0;
         scr_q   <= '0;
         cnt_q   <= '0;
         negp_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         bcd_q   <= '0;
         neg_q   <= 1'b0;
         ndig_q  <= 3'd1;
         flags_q <= 4'd0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         scr_q   <= scr_d;
         cnt_q   <= cnt_d;
         negp_q  <= negp_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         bcd_q   <= bcd_d;
         neg_q   <= neg_d;
         ndig_q  <= ndig_d;
         flags_q <= flags_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.bcd     = bcd_q;
   assign bus.neg     = neg_q;
   assign bus.ndig    = ndig_q;
   assign bus.flags_q = flags_q;
endmodule

// File: tb/tb_result_bcd_converter.sv
// Bench for result_bcd_converter: vector table, random
// values against a decimal model, and timing corner cases.
`timescale 1ns/1ps
module tb_result_bcd_converter;
   logic clk;
   logic rst_n;
   int   compared;
   int   mismatched;
   int   cyc;

   result_bcd_converter_if #(.WIDTH(16), .DIGITS(5)) bus ();

   result_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] r;
      logic        sm;
      logic [3:0]  fl;
      logic [19:0] bcd;
      logic        neg;
      logic [2:0]  nd;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h want %0h",
                  name, act, exp);
      end
   endtask

   function automatic int model_mag(
      input logic [15:0] r, input logic sm);
      int v;
      v = int'(r);
      if (sm && r[15]) v = 65536 - v;
      return v;
   endfunction

   function automatic logic [19:0] model_bcd(input int v);
      logic [19:0] b;
      b = '0;
      for (int i = 0; i < 5; i++) begin
         b[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return b;
   endfunction

   function automatic logic [2:0] model_nd(input int v);
      int n;
      n = 1;
      while (v >= 10) begin
         v = v / 10;
         n++;
      end
      return 3'(n);
   endfunction

   task automatic drive(input logic [15:0] r,
                        input logic sm,
                        input logic [3:0] fl);
      bus.result      = r;
      bus.signed_mode = sm;
      {bus.z_in, bus.n_in, bus.c_in, bus.o_in} = fl;
      bus.start = 1'b1;
   endtask

   task automatic convert(input logic [15:0] r,
                          input logic sm,
                          input logic [3:0] fl,
                          input string tag);
      int k;
      logic [19:0] prev;
      @(negedge clk);
      drive(r, sm, fl);
      prev = bus.bcd;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk({tag, " busy_at_capture"}, 32'(bus.busy), 1);
      chk({tag, " bcd_hold"}, 32'(bus.bcd), 32'(prev));
      k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while (!bus.done && k < 40);
      chk({tag, " latency"}, k, 16);
      chk({tag, " busy_at_done"}, 32'(bus.busy), 0);
      @(posedge clk);
      #1;
      chk({tag, " done_pulse"}, 32'(bus.done), 0);
   endtask

   task automatic check_out(input string tag,
                            input logic [19:0] b,
                            input logic n,
                            input logic [2:0] d,
                            input logic [3:0] f);
      chk({tag, " bcd"}, 32'(bus.bcd), 32'(b));
      chk({tag, " neg"}, 32'(bus.neg), 32'(n));
      chk({tag, " ndig"}, 32'(bus.ndig), 32'(d));
      chk({tag, " flags"}, 32'(bus.flags_q), 32'(f));
   endtask

   initial begin : main
      int k;
      int dones;
      int t1;
      int t2;
      logic [15:0] r;
      logic        sm;
      logic [3:0]  fl;
      int          v;

      compared   = 0;
      mismatched = 0;
      vecs[0] = '{16'hFFFF, 1'b0, 4'b0000, 20'h65535, 1'b0, 3'd5};
      vecs[1] = '{16'hFFF6, 1'b1, 4'b0100, 20'h00010, 1'b1, 3'd2};
      vecs[2] = '{16'h8000, 1'b1, 4'b0000, 20'h32768, 1'b1, 3'd5};
      vecs[3] = '{16'h8000, 1'b0, 4'b0000, 20'h32768, 1'b0, 3'd5};
      vecs[4] = '{16'h0000, 1'b0, 4'b1010, 20'h00000, 1'b0, 3'd1};
      vecs[5] = '{16'd999,  1'b0, 4'b0001, 20'h00999, 1'b0, 3'd3};
      vecs[6] = '{16'd1234, 1'b1, 4'b0011, 20'h01234, 1'b0, 3'd4};
      vecs[7] = '{16'h7FFF, 1'b1, 4'b0000, 20'h32767, 1'b0, 3'd5};
      vecs[8] = '{16'hFFFF, 1'b1, 4'b0100, 20'h00001, 1'b1, 3'd1};
      vecs[9] = '{16'd10000, 1'b0, 4'b1111, 20'h10000, 1'b0, 3'd5};

      bus.start       = 1'b0;
      bus.signed_mode = 1'b0;
      bus.result      = '0;
      bus.z_in = 1'b0;
      bus.n_in = 1'b0;
      bus.c_in = 1'b0;
      bus.o_in = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", 32'(bus.busy), 0);
      chk("reset done", 32'(bus.done), 0);
      check_out("reset", 20'h0, 1'b0, 3'd1, 4'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         convert(vecs[i].r, vecs[i].sm, vecs[i].fl,
                 $sformatf("vec%0d", i));
         check_out($sformatf("vec%0d", i), vecs[i].bcd,
                   vecs[i].neg, vecs[i].nd, vecs[i].fl);
      end

      for (int i = 0; i < 40; i++) begin
         r  = 16'($urandom);
         sm = 1'($urandom_range(0, 1));
         fl = 4'($urandom);
         v  = model_mag(r, sm);
         convert(r, sm, fl, $sformatf("rnd%0d", i));
         check_out($sformatf("rnd%0d", i), model_bcd(v),
                   sm & r[15], model_nd(v), fl);
      end

      // start pulsed during SHIFT must not disturb 1234
      @(negedge clk);
      drive(16'd1234, 1'b0, 4'b0000);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      drive(16'd1, 1'b0, 4'b1111);
      dones = 0;
      k = 0;
      while (dones == 0 && k < 40) begin
         @(posedge clk);
         #1;
         k++;
         if (bus.done) dones++;
      end
      bus.start = 1'b0;
      check_out("ignore", 20'h01234, 1'b0, 3'd4, 4'd0);
      repeat (25) begin
         @(posedge clk);
         #1;
         if (bus.done) dones++;
      end
      chk("ignore done_count", dones, 1);
      chk("ignore bcd_after", 32'(bus.bcd), 32'h01234);

      // reset in the middle of a conversion
      @(negedge clk);
      drive(16'd4321, 1'b1, 4'b0110);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst busy", 32'(bus.busy), 0);
      chk("midrst done", 32'(bus.done), 0);
      check_out("midrst", 20'h0, 1'b0, 3'd1, 4'd0);
      dones = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (bus.done) dones++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (bus.done) dones++;
      end
      chk("midrst no_done", dones, 0);
      convert(16'd999, 1'b0, 4'b0000, "restart");
      check_out("restart", 20'h00999, 1'b0, 3'd3, 4'd0);

      // start held high: captures 18 cycles apart
      @(negedge clk);
      drive(16'd1, 1'b0, 4'b0000);
      @(posedge clk);
      #1;
      bus.result = 16'd2;
      t1 = -1;
      t2 = -1;
      k  = 0;
      while (t2 < 0 && k < 60) begin
         @(posedge clk);
         #1;
         k++;
         if (bus.done) begin
            if (t1 < 0) begin
               t1 = cyc;
               chk("b2b first_bcd", 32'(bus.bcd), 32'h1);
            end else begin
               t2 = cyc;
               chk("b2b second_bcd", 32'(bus.bcd), 32'h2);
            end
         end
      end
      bus.start = 1'b0;
      chk("b2b first_latency_seen", 32'(t1 >= 0), 1);
      chk("b2b gap", t2 - t1, 18);
      repeat (3) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end
endmodule

// File: doc/result_bcd_converter.md
# result_bcd_converter

Sequential binary-to-BCD converter for the pocket calculator datapath. It captures the 16-bit ALU result and the Z/N/C/O flags on a start pulse, and converts the magnitude to five packed BCD digits with an iterative shift-and-add-3 (double-dabble) loop. It reports sign and significant-digit count for the display driver. It sits between the ALU output and the seven-segment/LCD front end.

## Interface
- WIDTH, 16, binary input width; the design is verified only at 16.
- DIGITS, 5, BCD output digits; 4·DIGITS bits of output.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request conversion; sampled only in IDLE.
- signed_mode  in  1  1 = treat result as two's complement; 0 = unsigned.
- result  in  16  ALU result to convert; sampled with start.
- z_in, n_in, c_in, o_in  in  1 each  ALU flags; sampled with start.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse; outputs are valid from this cycle on.
- bcd  out  20  packed digits, [19:16] = ten-thousands … [3:0] = units.
- neg  out  1  value was negative (signed_mode only).
- ndig  out  3  count of significant digits, 1..5.
- flags_q  out  4  captured {Z,N,C,O}.

## Operation
- States: IDLE, SHIFT, DONE.
- Reset (asynchronous, any state): go to IDLE. busy=0, done=0, bcd=0, neg=0, ndig=1, flags_q=0. Internal shift register and counter cleared. Any conversion in progress is abandoned with no done pulse.
- IDLE with start=1: capture flags_q ← {z_in,n_in,c_in,o_in}.
  - If signed_mode=1 and result[15]=1: magnitude = (~result)+1 (16-bit) and neg_pending=1.
  - Otherwise magnitude = result and neg_pending=0.
  - Load the magnitude into the binary shift register, clear the 20-bit BCD scratch, set count=0, busy=1, go to SHIFT.
- 0x8000 in signed mode: magnitude 32768; the 16-bit negate wraps back to 0x8000, which read as unsigned is correct.
- SHIFT, once per cycle: every scratch nibble ≥5 gets +3, then {scratch,binary} shifts left 1. count increments.
  - After the 16th shift (count==15 at the edge), latch bcd ← final scratch, neg ← neg_pending, ndig ← computed digit count, done=1, busy=0, go to DONE.
- DONE: one cycle. done returns to 0 and the state returns to IDLE. start is ignored in DONE.
- ndig = position of the highest nonzero digit + 1. A value of 0 gives ndig=1.
- start while busy or in DONE: ignored. No queueing. Captured values are unchanged.
- Input changes after the capture edge do not affect the conversion.
- bcd, neg, ndig and flags_q hold their last values until the next done. They do not change at the capture edge.
- Unsigned range 0..65535 and signed range −32768..32767 always fit in 5 digits. No overflow output exists.

## Timing
- Capture edge E0 (start=1 in IDLE). busy is 1 from after E0 through E16.
- Shifts occur at E1..E16. At E16: done=1, busy=0, and the outputs are updated.
- At E17: done=0, state is IDLE.
- The earliest accepted next start is sampled at E18, giving a throughput of 18 cycles per conversion.
- Latency is 16 cycles from the capture edge to done.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Unsigned max: result=0xFFFF, signed_mode=0 → done exactly 16 cycles after the capture edge, bcd=0x65535, neg=0, ndig=5.
- Signed negative: result=0xFFF6, signed_mode=1, n_in=1 → bcd=0x00010, neg=1, ndig=2, flags_q=4'b0100.
- Signed minimum: result=0x8000, signed_mode=1 → bcd=0x32768, neg=1, ndig=5. The same input with signed_mode=0 → bcd=0x32768, neg=0.
- Zero and flags: result=0, z_in=1, c_in=1 → bcd=0, ndig=1, flags_q=4'b1010.
- Ignored start: start=1 with result=0x0001 during SHIFT of a conversion of 1234 → only one done, bcd=0x01234, ndig=4.
- Reset and restart: assert rst_n=0 at the 8th SHIFT cycle → all outputs immediately at reset values and no done. Release rst_n, then convert 999 → bcd=0x00999, ndig=3.
- Back-to-back: start held high continuously with 1 then 2 → the second capture occurs at E18 and done pulses are 18 cycles apart.
